keypad_scan: RTL and testbench

Matrix keypad scanner for the 4x4 input pad: the input-side counterpart of the seven-segment digit scanner. The scanner drives one keypad column low at a time, samples the active-low rows, and debounces a single pressed key over several scan ticks. It reports the key to game control as a 4-bit code with a one-cycle valid pulse and a held level. It sits between the board pins and the Tetris control FSM and is clocked from the same divided scan clock domain as the display.

---
 rtl/keypad_pkg.sv | 17 +
 rtl/sync_2ff.sv | 32 +++
 rtl/keypad_scan.sv | 169 ++++++++++++++++
 tb/tb_keypad_scan.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM encoding, idle pattern
// and the one-hot active-low column decode also used by the display scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam logic [3:0] COL_IDLE = 4'b1111;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the externally pulled-up keypad rows; resets to all
// ones so an idle pad reads as no key.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates the column drive, debounces a single key
// over DEBOUNCE_SCANS scan ticks and reports it as {col,row} with valid/held.
//
// state    | meaning
// SCAN     | rotating columns, waiting for exactly one low row
// DEBOUNCE | column frozen, counting consecutive matching ticks
// HELD     | key accepted, counting idle ticks until release
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic [3:0] row_s;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (row_n),
    .q_out (row_s)
  );

  logic [2:0] row_zeros;
  logic [1:0] row_idx;
  logic       row_single;

  always_comb begin
    row_zeros = 3'd0;
    row_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_s[i]) begin
        row_zeros = row_zeros + 3'd1;
        row_idx   = 2'(i);
      end
    end
    row_single = (row_zeros == 3'd1);
  end

  state_e     state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [1:0] cand_col_q, cand_col_d;
  logic [1:0] cand_row_q, cand_row_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic [3:0] col_n_q, col_n_d;

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cand_col_d  = cand_col_q;
    cand_row_d  = cand_row_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (scan_en) begin
      case (state_q)
        SCAN: begin
          if (row_single) begin
            cand_col_d = col_idx_q;
            cand_row_d = row_idx;
            // A single required match accepts on the very first tick.
            if (DS == 4'd1) begin
              key_code_d  = {col_idx_q, row_idx};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = 4'd0;
              state_d     = HELD;
            end else begin
              cnt_d   = 4'd1;
              state_d = DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (row_single && (row_idx == cand_row_q)) begin
            if (cnt_q + 4'd1 == DS) begin
              key_code_d  = {cand_col_q, cand_row_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = 4'd0;
              state_d     = HELD;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d     = 4'd0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end

        HELD: begin
          if (row_s == COL_IDLE) begin
            if (rcnt_q + 4'd1 == DS) begin
              rcnt_d     = 4'd0;
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = SCAN;
            end else begin
              rcnt_d = rcnt_q + 4'd1;
            end
          end else begin
            rcnt_d = 4'd0;
          end
        end

        default: begin
          state_d = SCAN;
          cnt_d   = 4'd0;
          rcnt_d  = 4'd0;
        end
      endcase
    end

    col_n_d = col_drive(col_idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      cand_col_q  <= 2'd0;
      cand_row_q  <= 2'd0;
      cnt_q       <= 4'd0;
      rcnt_q      <= 4'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      col_n_q     <= 4'b1110;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cand_col_q  <= cand_col_d;
      cand_row_q  <= cand_row_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      col_n_q     <= col_n_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model drives the rows from the
// column drive; per-tick expectations come from a vector table via a queue.
module tb_keypad_scan;

  logic       clk;
  logic       rst_n, rst_n_b;
  logic       scan_en;
  logic [3:0] row_n_a, row_n_b;
  logic [3:0] col_n_a, col_n_b;
  logic [3:0] key_code_a, key_code_b;
  logic       key_valid_a, key_valid_b;
  logic       key_held_a, key_held_b;

  keypad_scan #(.DEBOUNCE_SCANS(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .row_n     (row_n_a),
    .col_n     (col_n_a),
    .key_code  (key_code_a),
    .key_valid (key_valid_a),
    .key_held  (key_held_a)
  );

  keypad_scan #(.DEBOUNCE_SCANS(1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n_b),
    .scan_en   (scan_en),
    .row_n     (row_n_b),
    .col_n     (col_n_b),
    .key_code  (key_code_b),
    .key_valid (key_valid_b),
    .key_held  (key_held_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low only while its column is driven.
  logic       key_a_down, ghost_a, key_b_down;
  logic [1:0] key_a_col, key_a_row, key_b_col, key_b_row;

  always_comb begin
    row_n_a = 4'hF;
    if (ghost_a) row_n_a = 4'b1010;
    else if (key_a_down && !col_n_a[key_a_col]) row_n_a[key_a_row] = 1'b0;
    row_n_b = 4'hF;
    if (key_b_down && !col_n_b[key_b_col]) row_n_b[key_b_row] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int valid_cnt_a = 0;

  always @(posedge clk) if (key_valid_a) valid_cnt_a++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Settle rows, pulse scan_en for one cycle, return on the cycle after the tick.
  task automatic tick();
    repeat (5) @(negedge clk);
    scan_en = 1'b1;
    @(negedge clk);
    scan_en = 1'b0;
  endtask

  typedef struct packed {
    logic       down;
    logic       ghost;
    logic [3:0] e_col_n;
    logic       e_valid;
    logic       e_held;
    logic [3:0] e_code;
  } vec_t;

  typedef struct packed {
    logic [3:0] col_n;
    logic       valid;
    logic       held;
    logic [3:0] code;
  } exp_t;

  vec_t vecs[32];
  exp_t sb[$];

  function automatic vec_t mk(input logic d, input logic g, input logic [3:0] c,
                              input logic v, input logic h, input logic [3:0] k);
    vec_t r;
    r.down = d; r.ghost = g; r.e_col_n = c; r.e_valid = v; r.e_held = h; r.e_code = k;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit   got;

    // Press, hold, release of key (col1,row2), then bounce, then ghost rows.
    vecs[0]  = mk(1, 0, 4'b1101, 0, 0, 4'h0);
    vecs[1]  = mk(1, 0, 4'b1101, 0, 0, 4'h0);
    vecs[2]  = mk(1, 0, 4'b1101, 0, 0, 4'h0);
    vecs[3]  = mk(1, 0, 4'b1101, 0, 0, 4'h0);
    vecs[4]  = mk(1, 0, 4'b1101, 1, 1, 4'h6);
    vecs[5]  = mk(1, 0, 4'b1101, 0, 1, 4'h6);
    vecs[6]  = mk(0, 0, 4'b1101, 0, 1, 4'h6);
    vecs[7]  = mk(0, 0, 4'b1101, 0, 1, 4'h6);
    vecs[8]  = mk(0, 0, 4'b1101, 0, 1, 4'h6);
    vecs[9]  = mk(0, 0, 4'b1011, 0, 0, 4'h6);
    vecs[10] = mk(0, 0, 4'b0111, 0, 0, 4'h6);
    vecs[11] = mk(0, 0, 4'b1110, 0, 0, 4'h6);
    vecs[12] = mk(0, 0, 4'b1101, 0, 0, 4'h6);
    vecs[13] = mk(1, 0, 4'b1101, 0, 0, 4'h6);
    vecs[14] = mk(1, 0, 4'b1101, 0, 0, 4'h6);
    vecs[15] = mk(0, 0, 4'b1011, 0, 0, 4'h6);
    vecs[16] = mk(1, 0, 4'b0111, 0, 0, 4'h6);
    vecs[17] = mk(1, 0, 4'b1110, 0, 0, 4'h6);
    vecs[18] = mk(1, 0, 4'b1101, 0, 0, 4'h6);
    vecs[19] = mk(1, 0, 4'b1101, 0, 0, 4'h6);
    vecs[20] = mk(1, 0, 4'b1101, 0, 0, 4'h6);
    vecs[21] = mk(1, 0, 4'b1101, 0, 0, 4'h6);
    vecs[22] = mk(1, 0, 4'b1101, 1, 1, 4'h6);
    vecs[23] = mk(0, 0, 4'b1101, 0, 1, 4'h6);
    vecs[24] = mk(0, 0, 4'b1101, 0, 1, 4'h6);
    vecs[25] = mk(0, 0, 4'b1101, 0, 1, 4'h6);
    vecs[26] = mk(0, 0, 4'b1011, 0, 0, 4'h6);
    vecs[27] = mk(0, 1, 4'b0111, 0, 0, 4'h6);
    vecs[28] = mk(0, 1, 4'b1110, 0, 0, 4'h6);
    vecs[29] = mk(0, 1, 4'b1101, 0, 0, 4'h6);
    vecs[30] = mk(0, 1, 4'b1011, 0, 0, 4'h6);
    vecs[31] = mk(0, 1, 4'b0111, 0, 0, 4'h6);

    rst_n = 1'b0; rst_n_b = 1'b0; scan_en = 1'b0;
    key_a_down = 1'b0; ghost_a = 1'b0; key_a_col = 2'd1; key_a_row = 2'd2;
    key_b_down = 1'b0; key_b_col = 2'd3; key_b_row = 2'd3;
    repeat (3) @(negedge clk);
    chk("reset_col_n", col_n_a, 4'b1110);
    chk("reset_code", key_code_a, 4'h0);
    chk("reset_valid", key_valid_a, 1'b0);
    chk("reset_held", key_held_a, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      key_a_down = vecs[i].down;
      ghost_a    = vecs[i].ghost;
      sb.push_back({vecs[i].e_col_n, vecs[i].e_valid, vecs[i].e_held, vecs[i].e_code});
      tick();
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: vector %0d has no expectation", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_col_n", i), col_n_a, e.col_n);
        chk($sformatf("v%0d_valid", i), key_valid_a, e.valid);
        chk($sformatf("v%0d_held", i), key_held_a, e.held);
        chk($sformatf("v%0d_code", i), key_code_a, e.code);
        if (e.valid) begin
          @(negedge clk);
          chk($sformatf("v%0d_pulse_width", i), key_valid_a, 1'b0);
        end
      end
    end
    ghost_a = 1'b0;

    // Reset in the middle of a debounce of key (col3,row0).
    key_a_col = 2'd3; key_a_row = 2'd0; key_a_down = 1'b1;
    tick();
    chk("rst_seq_match1_col", col_n_a, 4'b0111);
    tick();
    chk("rst_seq_match2_valid", key_valid_a, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_col_n", col_n_a, 4'b1110);
    chk("rst_async_held", key_held_a, 1'b0);
    chk("rst_async_code", key_code_a, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_valid", key_valid_a, 1'b0);
    got = 1'b0;
    for (int n = 1; n <= 12 && !got; n++) begin
      tick();
      if (key_valid_a) begin
        got = 1'b1;
        chk("rst_fresh_ticks", n, 7);
        chk("rst_fresh_code", key_code_a, 4'b1100);
        chk("rst_fresh_held", key_held_a, 1'b1);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rst_fresh_timeout: got no key_valid expected one within 12 ticks");
    end
    key_a_down = 1'b0;
    @(negedge clk);
    chk("total_valid_pulses", valid_cnt_a, 3);

    // DEBOUNCE_SCANS = 1: key (col3,row3) accepted on its first matching tick.
    rst_n_b = 1'b0;
    @(negedge clk);
    rst_n_b = 1'b1;
    key_b_down = 1'b1;
    tick(); chk("b_t1_col", col_n_b, 4'b1101);
    tick(); chk("b_t2_col", col_n_b, 4'b1011);
    tick(); chk("b_t3_col", col_n_b, 4'b0111);
    chk("b_t3_valid", key_valid_b, 1'b0);
    tick();
    chk("b_accept_valid", key_valid_b, 1'b1);
    chk("b_accept_code", key_code_b, 4'hF);
    chk("b_accept_held", key_held_b, 1'b1);
    chk("b_accept_col", col_n_b, 4'b0111);
    @(negedge clk);
    chk("b_pulse_width", key_valid_b, 1'b0);
    key_b_down = 1'b0;
    tick();
    chk("b_release_held", key_held_b, 1'b0);
    chk("b_release_col", col_n_b, 4'b1110);
    chk("b_release_code", key_code_b, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
